// File: rtl/bsg_tag_serializer.sv
// bsg_tag_serializer: bit-serial transmitter for the bsg_tag protocol.
// Accepts one parallel tag packet per v_i/ready_o handshake and shifts it out
// LSB first on tag_data_o/tag_en_o:
//   start(1), node_id(id_width), data_not_reset(1), len(lg_width_p), payload(len)
// followed by gap_p forced-idle cycles.
// Optional feature: define BSG_TAG_SERIALIZER_PREAMBLE_EN to emit a tag-master
// reset preamble (preamble_ones_p enabled ones, then preamble_ones_p enabled
// zeros) after every reset, before the first packet is accepted.
module bsg_tag_serializer #(
  parameter int els_p               = 32,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 15,
  parameter int gap_p               = 2,
  parameter int preamble_ones_p     = 64,
  localparam int id_width_lp        = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [id_width_lp-1:0]         node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_en_o,
  output logic                           tag_data_o,
  output logic                           err_o
);

  // Down-counter must hold the longest field length minus one, the payload
  // length, the gap length and the full preamble count without wrapping.
  localparam int pay_cnt_w_lp = $clog2(max_payload_width_p + 1);
  localparam int pre_cnt_w_lp = $clog2(preamble_ones_p + 1);
  localparam int gap_cnt_w_lp = $clog2(gap_p + 1);
  localparam int cnt_w_a_lp   = (id_width_lp > lg_width_p) ? id_width_lp : lg_width_p;
  localparam int cnt_w_b_lp   = (cnt_w_a_lp > pay_cnt_w_lp) ? cnt_w_a_lp : pay_cnt_w_lp;
  localparam int cnt_w_c_lp   = (cnt_w_b_lp > pre_cnt_w_lp) ? cnt_w_b_lp : pre_cnt_w_lp;
  localparam int cnt_w_lp     = (cnt_w_c_lp > gap_cnt_w_lp) ? cnt_w_c_lp : gap_cnt_w_lp;

  // Whole packet image: start bit in bit 0, payload in the top bits.
  localparam int shift_w_lp = 2 + id_width_lp + lg_width_p + max_payload_width_p;

  localparam logic [lg_width_p-1:0] max_len_lp = lg_width_p'(max_payload_width_p);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_DNR,
    S_LEN,
    S_PAYLOAD,
    S_GAP
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
    , S_PREAMBLE_ONES
    , S_PREAMBLE_ZEROS
`endif
  } state_e;

`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
  // The first cycle out of reset still shows the reset (idle) outputs, so the
  // ones phase is loaded with the full count rather than count-1; that makes
  // exactly preamble_ones_p enabled ones appear on the line.
  localparam state_e              reset_state_lp = S_PREAMBLE_ONES;
  localparam logic [cnt_w_lp-1:0] reset_cnt_lp   = cnt_w_lp'(preamble_ones_p);
`else
  localparam state_e              reset_state_lp = S_IDLE;
  localparam logic [cnt_w_lp-1:0] reset_cnt_lp   = '0;
`endif

  localparam logic [cnt_w_lp-1:0] one_lp      = cnt_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] id_last_lp  = cnt_w_lp'(id_width_lp - 1);
  localparam logic [cnt_w_lp-1:0] len_last_lp = cnt_w_lp'(lg_width_p - 1);
  localparam logic [cnt_w_lp-1:0] gap_last_lp = cnt_w_lp'(gap_p - 1);

  state_e                  state_q, state_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [shift_w_lp-1:0]   shift_q, shift_d;
  logic [lg_width_p-1:0]   len_q, len_d;
  logic                    ready_q, ready_d;
  logic                    tag_en_q, tag_en_d;
  logic                    tag_data_q, tag_data_d;
  logic                    err_q, err_d;

  logic handshake;
  assign handshake = v_i & ready_q;

  // Next-state, field sequencing and next-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    err_d      = 1'b0;
    ready_d    = 1'b0;
    tag_en_d   = 1'b0;
    tag_data_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          if (len_i > max_len_lp) begin
            // Oversize packet: report and stay idle, nothing goes on the line.
            err_d = 1'b1;
          end else begin
            state_d = S_START;
            shift_d = {payload_i, len_i, data_not_reset_i, node_id_i, 1'b1};
            len_d   = len_i;
          end
        end
      end

      S_START: begin
        state_d = S_ID;
        cnt_d   = id_last_lp;
        shift_d = shift_q >> 1;
      end

      S_ID: begin
        shift_d = shift_q >> 1;
        if (cnt_q == '0) state_d = S_DNR;
        else             cnt_d   = cnt_q - one_lp;
      end

      S_DNR: begin
        state_d = S_LEN;
        cnt_d   = len_last_lp;
        shift_d = shift_q >> 1;
      end

      S_LEN: begin
        shift_d = shift_q >> 1;
        if (cnt_q == '0) begin
          if (len_q != '0) begin
            state_d = S_PAYLOAD;
            cnt_d   = cnt_w_lp'(len_q) - one_lp;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_last_lp;
          end
        end else begin
          cnt_d = cnt_q - one_lp;
        end
      end

      S_PAYLOAD: begin
        shift_d = shift_q >> 1;
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = gap_last_lp;
        end else begin
          cnt_d = cnt_q - one_lp;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - one_lp;
      end

`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
      S_PREAMBLE_ONES: begin
        if (cnt_q == '0) begin
          state_d = S_PREAMBLE_ZEROS;
          cnt_d   = cnt_w_lp'(preamble_ones_p - 1);
        end else begin
          cnt_d = cnt_q - one_lp;
        end
      end

      S_PREAMBLE_ZEROS: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - one_lp;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so that the line always
    // reflects the state the FSM is in during that cycle.
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_START, S_ID, S_DNR, S_LEN, S_PAYLOAD: begin
        tag_en_d   = 1'b1;
        tag_data_d = shift_d[0];
      end
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
      S_PREAMBLE_ONES: begin
        tag_en_d   = 1'b1;
        tag_data_d = 1'b1;
      end
      S_PREAMBLE_ZEROS: begin
        tag_en_d   = 1'b1;
        tag_data_d = 1'b0;
      end
`endif
      default: begin
        tag_en_d   = 1'b0;
        tag_data_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= reset_state_lp;
      cnt_q      <= reset_cnt_lp;
      shift_q    <= '0;
      len_q      <= '0;
      ready_q    <= 1'b0;
      tag_en_q   <= 1'b0;
      tag_data_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      ready_q    <= ready_d;
      tag_en_q   <= tag_en_d;
      tag_data_q <= tag_data_d;
      err_q      <= err_d;
    end
  end

  assign ready_o    = ready_q;
  assign tag_en_o   = tag_en_q;
  assign tag_data_o = tag_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_bsg_tag_serializer.sv
// Self-checking bench for bsg_tag_serializer (max payload 10 so oversize
// lengths 11..15 are reachable). Expected line contents come from a packet
// bit-list model built from the wire format.
`timescale 1ns/1ps
module tb_bsg_tag_serializer;

  localparam int ELS  = 32;
  localparam int LG   = 4;
  localparam int MAXP = 10;
  localparam int GAP  = 2;
  localparam int PRE  = 64;
  localparam int IDW  = 5;
`ifdef BSG_TAG_SERIALIZER_PREAMBLE_EN
  localparam int PRE_EFF = PRE;
`else
  localparam int PRE_EFF = 0;
`endif
  // Sample index (counting from the first edge with reset low) where ready rises.
  localparam int RST_LAT = 2 * PRE_EFF;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic            v_i = 1'b0;
  logic            ready_o;
  logic [IDW-1:0]  node_id_i = '0;
  logic            data_not_reset_i = 1'b0;
  logic [LG-1:0]   len_i = '0;
  logic [MAXP-1:0] payload_i = '0;
  logic            tag_en_o;
  logic            tag_data_o;
  logic            err_o;

  int tests = 0;
  int fails = 0;

  bit         exp_q[$];
  logic [3:0] cap [0:255];   // {tag_en, tag_data, ready, err}

  bsg_tag_serializer #(
    .els_p(ELS), .lg_width_p(LG), .max_payload_width_p(MAXP),
    .gap_p(GAP), .preamble_ones_p(PRE)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .node_id_i(node_id_i), .data_not_reset_i(data_not_reset_i),
    .len_i(len_i), .payload_i(payload_i),
    .tag_en_o(tag_en_o), .tag_data_o(tag_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference model: ordered list of bits a packet puts on the line.
  task automatic build_expected(input logic [IDW-1:0] id, input logic dnr,
                                input logic [LG-1:0] len, input logic [MAXP-1:0] pl);
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < IDW; i++) exp_q.push_back(id[i]);
    exp_q.push_back(dnr);
    for (int i = 0; i < LG; i++) exp_q.push_back(len[i]);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(pl[i]);
  endtask

  // Wait (bounded) for ready, then present one packet for a single cycle.
  task automatic issue(input logic [IDW-1:0] id, input logic dnr,
                       input logic [LG-1:0] len, input logic [MAXP-1:0] pl);
    int waited = 0;
    while (ready_o !== 1'b1 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    tests++;
    if (ready_o !== 1'b1) begin
      fails++;
      $display("FAIL issue_wait ready_o=%b required 1 within 400 cycles", ready_o);
    end
    node_id_i = id; data_not_reset_i = dnr; len_i = len; payload_i = pl;
    v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap[i] = {tag_en_o, tag_data_o, ready_o, err_o};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] want;
    reset_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if ({tag_en_o, tag_data_o, ready_o, err_o} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_values {en,data,ready,err} got %b required 0000",
                 {tag_en_o, tag_data_o, ready_o, err_o});
      end
    end
    reset_i = 1'b0;
    @(posedge clk); #1;
    capture(RST_LAT + 1);
    for (int k = 0; k <= RST_LAT; k++) begin
      want = (k < PRE_EFF) ? 4'b1100 : (k < 2 * PRE_EFF) ? 4'b1000 : 4'b0010;
      tests++;
      if (cap[k] !== want) begin
        fails++;
        $display("FAIL reset_exit k=%0d {en,data,ready,err} got %b required %b", k, cap[k], want);
      end
    end
    $display("[TB] reset: ready after %0d cycles", RST_LAT + 1);
  endtask

  task automatic test_mid_reset();
    logic [3:0] want;
    issue(5'd9, 1'b1, 4'd8, 10'h2a5);
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (tag_en_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_in_len tag_en_o=%b required 1", tag_en_o);
    end
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    tests++;
    if ({tag_en_o, tag_data_o, ready_o, err_o} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset_abort {en,data,ready,err} got %b required 0000",
               {tag_en_o, tag_data_o, ready_o, err_o});
    end
    @(posedge clk); #1;
    capture(RST_LAT + 1);
    for (int k = 0; k <= RST_LAT; k++) begin
      want = (k < PRE_EFF) ? 4'b1100 : (k < 2 * PRE_EFF) ? 4'b1000 : 4'b0010;
      tests++;
      if (cap[k] !== want) begin
        fails++;
        $display("FAIL mid_reset_recover k=%0d {en,data,ready,err} got %b required %b", k, cap[k], want);
      end
    end
    $display("[TB] mid-packet reset during LEN field");
  endtask

  // Directed nominal and len-0 packets, then randomized packets.
  task automatic test_data_packets();
    logic [IDW-1:0]  id;
    logic            dnr;
    logic [LG-1:0]   len;
    logic [MAXP-1:0] pl;
    logic [3:0]      want;
    int nb;
    int bad;
    for (int p = 0; p < 24; p++) begin
      if (p == 0) begin
        id = 5'd3; dnr = 1'b1; len = 4'd4; pl = 10'b0000001011;
      end else if (p == 1) begin
        id = 5'd31; dnr = 1'b0; len = 4'd0; pl = MAXP'($urandom);
      end else begin
        id = IDW'($urandom_range(ELS - 1, 0)); dnr = 1'($urandom);
        len = LG'($urandom_range(MAXP, 0)); pl = MAXP'($urandom);
      end
      build_expected(id, dnr, len, pl);
      nb = exp_q.size();
      issue(id, dnr, len, pl);
      capture(nb + GAP + 1);
      bad = 0;
      for (int i = 0; i < nb + GAP + 1; i++) begin
        if (i < nb)            want = {1'b1, exp_q[i], 2'b00};
        else if (i < nb + GAP) want = 4'b0000;
        else                   want = 4'b0010;
        tests++;
        if (cap[i] !== want) begin
          fails++; bad++;
          $display("FAIL pkt%0d cycle%0d {en,data,ready,err} got %b required %b", p, i, cap[i], want);
        end
      end
      $display("[TB] pkt%0d id=%0d dnr=%0d len=%0d payload=%h bits=%0d errors=%0d",
               p, id, dnr, len, pl, nb, bad);
    end
  endtask

  task automatic test_oversize();
    logic [LG-1:0] len;
    for (int n = 0; n < 4; n++) begin
      len = LG'($urandom_range(15, MAXP + 1));
      issue(IDW'($urandom), 1'b1, len, MAXP'($urandom));
      capture(4);
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (cap[i] !== ((i == 0) ? 4'b0011 : 4'b0010)) begin
          fails++;
          $display("FAIL oversize len=%0d cycle%0d {en,data,ready,err} got %b required %b",
                   len, i, cap[i], (i == 0) ? 4'b0011 : 4'b0010);
        end
      end
      $display("[TB] oversize len=%0d rejected", len);
    end
  endtask

  task automatic test_back_to_back();
    bit line_q[$];
    int hs[$];
    int pk = 0;
    bit just_hs = 0;
    logic [1:0] want;
    node_id_i = IDW'($urandom); data_not_reset_i = 1'($urandom);
    len_i = 4'd8; payload_i = MAXP'($urandom);
    v_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (just_hs) begin
        just_hs = 0;
        if (pk == 3) v_i = 1'b0;
        else begin
          node_id_i = IDW'($urandom); data_not_reset_i = 1'($urandom);
          payload_i = MAXP'($urandom);
        end
      end
      if (pk == 3 && line_q.size() == 0) break;
      want = (line_q.size() > 0) ? {1'b1, line_q.pop_front()} : 2'b00;
      tests++;
      if ({tag_en_o, tag_data_o} !== want) begin
        fails++;
        $display("FAIL b2b_line cycle%0d {en,data} got %b required %b", c, {tag_en_o, tag_data_o}, want);
      end
      if (ready_o === 1'b1 && v_i === 1'b1) begin
        hs.push_back(c);
        build_expected(node_id_i, data_not_reset_i, len_i, payload_i);
        foreach (exp_q[i]) line_q.push_back(exp_q[i]);
        pk++;
        just_hs = 1;
      end
      @(posedge clk); #1;
    end
    v_i = 1'b0;
    tests++;
    if (hs.size() != 3) begin
      fails++;
      $display("FAIL b2b_handshakes got %0d required 3", hs.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (hs[i] - hs[i-1] != 2 + IDW + LG + 8 + GAP + 1) begin
          fails++;
          $display("FAIL b2b_spacing got %0d required %0d", hs[i] - hs[i-1], 2 + IDW + LG + 8 + GAP + 1);
        end
      end
      $display("[TB] back-to-back handshakes at %0d %0d %0d", hs[0], hs[1], hs[2]);
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_data_packets();
    test_oversize();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
